// File: rtl/aes_dec_round_ctrl_if.sv
// Handshake and datapath bundle for the AES-128 inverse-cipher round controller.
// The slave modport is the controller's view; master is the surrounding system.
interface aes_dec_round_ctrl_if #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned IDX_W  = 4
);
  logic              key_wr_en;
  logic [IDX_W-1:0]  key_wr_idx;
  logic [DATA_W-1:0] key_wr_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              rnd_valid_o;
  logic [DATA_W-1:0] rnd_data_o;
  logic [DATA_W-1:0] rnd_key_o;
  logic              rnd_last_o;
  logic              rnd_valid_i;
  logic [DATA_W-1:0] rnd_data_i;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;

  modport slave (
    input  key_wr_en, key_wr_idx, key_wr_data,
    input  in_valid, in_data,
    output in_ready,
    output rnd_valid_o, rnd_data_o, rnd_key_o, rnd_last_o,
    input  rnd_valid_i, rnd_data_i,
    output out_valid, out_data,
    input  out_ready,
    output busy
  );

  modport master (
    output key_wr_en, key_wr_idx, key_wr_data,
    output in_valid, in_data,
    input  in_ready,
    input  rnd_valid_o, rnd_data_o, rnd_key_o, rnd_last_o,
    output rnd_valid_i, rnd_data_i,
    input  out_valid, out_data,
    output out_ready,
    input  busy
  );
endinterface

// File: rtl/aes_dec_round_ctrl.sv
// Sequencer for the AES-128 inverse-cipher round datapath: owns the round-key
// store, applies the initial AddRoundKey and walks one block through NR rounds.
module aes_dec_round_ctrl #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned NR     = 10,
  parameter int unsigned IDX_W  = 4
) (
  input logic                 clk,
  input logic                 reset,
  aes_dec_round_ctrl_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NR);
  localparam logic [IDX_W-1:0] FIRST_RND = IDX_W'(NR - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e            state;
  logic [IDX_W-1:0]  rcnt;
  logic [IDX_W-1:0]  rcnt_dec_c;
  logic              key_we_c;
  logic [DATA_W-1:0] key_mem [NR+1];

  assign rcnt_dec_c = rcnt - IDX_W'(1);
  assign key_we_c   = bus.key_wr_en && (bus.key_wr_idx <= LAST_IDX) && (state == IDLE);

  // Key store: writable only while idle so keys stay locked for a whole block.
  always_ff @(posedge clk) begin
    if (key_we_c) begin
      key_mem[bus.key_wr_idx] <= bus.key_wr_data;
    end
  end

  // Round sequencer; the issue registers are loaded on entry to ISSUE so they
  // are visible for exactly the one ISSUE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      rcnt            <= '0;
      bus.in_ready    <= 1'b0;
      bus.rnd_valid_o <= 1'b0;
      bus.rnd_data_o  <= '0;
      bus.rnd_key_o   <= '0;
      bus.rnd_last_o  <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      bus.busy        <= 1'b0;
    end else begin
      bus.rnd_valid_o <= 1'b0;
      bus.rnd_data_o  <= '0;
      bus.rnd_key_o   <= '0;
      bus.rnd_last_o  <= 1'b0;
      case (state)
        IDLE: begin
          bus.in_ready <= 1'b1;
          if (bus.in_valid && bus.in_ready) begin
            bus.in_ready    <= 1'b0;
            bus.busy        <= 1'b1;
            rcnt            <= FIRST_RND;
            state           <= ISSUE;
            bus.rnd_valid_o <= 1'b1;
            bus.rnd_data_o  <= bus.in_data ^ key_mem[LAST_IDX];
            bus.rnd_key_o   <= key_mem[FIRST_RND];
            bus.rnd_last_o  <= (FIRST_RND == '0);
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (bus.rnd_valid_i) begin
            if (rcnt == '0) begin
              state         <= DONE;
              bus.out_valid <= 1'b1;
              bus.out_data  <= bus.rnd_data_i;
            end else begin
              rcnt            <= rcnt_dec_c;
              state           <= ISSUE;
              bus.rnd_valid_o <= 1'b1;
              bus.rnd_data_o  <= bus.rnd_data_i;
              bus.rnd_key_o   <= key_mem[rcnt_dec_c];
              bus.rnd_last_o  <= (rcnt_dec_c == '0);
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.busy      <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Bench for aes_dec_round_ctrl: a 4-stage inverse-round datapath model feeds the
// controller; plaintexts are checked against an independent forward AES-128 cipher.
module tb_aes_dec_round_ctrl;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned NR     = 10;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned L      = 4;
  localparam int          LAT    = NR * (L + 1) + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_dec_round_ctrl_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();
  aes_dec_round_ctrl #(.DATA_W(DATA_W), .NR(NR), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk    [NR+1];

  // ---------------- AES arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic void build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox[a]  = s;
      isbox[s] = 8'(a);
    end
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    for (int i = 0; i < 16; i++)
      y[127-8*i -: 8] = inv ? isbox[x[127-8*i -: 8]] : sbox[x[127-8*i -: 8]];
    return y;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    int s;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        s = inv ? (c - r + 4) % 4 : (c + r) % 4;
        y[127-8*(4*c+r) -: 8] = x[127-8*(4*s+r) -: 8];
      end
    return y;
  endfunction

  function automatic logic [7:0] mcoef(input bit inv, input int k);
    case (k)
      0:       return inv ? 8'h0e : 8'h02;
      1:       return inv ? 8'h0b : 8'h03;
      2:       return inv ? 8'h0d : 8'h01;
      default: return inv ? 8'h09 : 8'h01;
    endcase
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    logic [7:0]   acc;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gm(mcoef(inv, (j - r + 4) % 4), x[127-8*(4*c+j) -: 8]);
        y[127-8*(4*c+r) -: 8] = acc;
      end
    return y;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic void expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Forward cipher: the independent source of ciphertext for every plaintext.
  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk[0];
    for (int r = 1; r < NR; r++) s = mix_cols(shift_rows(sub_bytes(s, 0), 0), 0) ^ rk[r];
    return shift_rows(sub_bytes(s, 0), 0) ^ rk[NR];
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] d, input logic [127:0] k,
                                             input logic last);
    logic [127:0] t;
    t = sub_bytes(shift_rows(d, 1), 1) ^ k;
    return last ? t : mix_cols(t, 1);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- round datapath model (L-stage pipeline) ----------------
  logic [L-1:0] pv;
  logic [127:0] pd [L];
  logic         spur = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pv <= '0;
    end else begin
      pv    <= {pv[L-2:0], bus.rnd_valid_o};
      pd[0] <= inv_round(bus.rnd_data_o, bus.rnd_key_o, bus.rnd_last_o);
      for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
    end
  end
  assign bus.rnd_valid_i = pv[L-1] | spur;
  assign bus.rnd_data_i  = pd[L-1];

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_keys(input logic [127:0] key);
    expand(key);
    for (int i = 0; i <= int'(NR); i++) begin
      bus.key_wr_en   = 1'b1;
      bus.key_wr_idx  = IDX_W'(i);
      bus.key_wr_data = rk[i];
      step();
    end
    bus.key_wr_en = 1'b0;
  endtask

  // mode: 0 plain, 1 spurious strobe in ISSUE, 2 key write mid-block, 3 expect wrong plaintext
  task automatic run_block(input logic [127:0] ct, input logic [127:0] exp, input string name,
                           input int hold, input int mode, input bit keep_valid,
                           input logic [127:0] next_ct, output int waited);
    int c, pulses, lastbad;
    logic [127:0] first;
    bus.in_valid = 1'b1;
    bus.in_data  = ct;
    waited = 0;
    while (!bus.in_ready && waited < 100) begin step(); waited++; end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s accept: in_ready=%b after %0d cycles, required 1", name, bus.in_ready, waited);
      bus.in_valid = 1'b0;
      return;
    end
    step();
    if (keep_valid) bus.in_data = next_ct;
    else bus.in_valid = 1'b0;
    c = 1; pulses = 0; lastbad = 0;
    while (bus.out_valid !== 1'b1 && c < 300) begin
      spur = 1'b0;
      bus.key_wr_en = 1'b0;
      if (bus.rnd_valid_o === 1'b1) begin
        pulses++;
        if (bus.rnd_last_o !== (pulses == int'(NR))) lastbad++;
        if (mode == 1 && pulses == 3) spur = 1'b1;
        if (mode == 2 && pulses == 4) begin
          bus.key_wr_en   = 1'b1;
          bus.key_wr_idx  = IDX_W'(5);
          bus.key_wr_data = '0;
        end
      end else if (bus.rnd_last_o !== 1'b0) lastbad++;
      step();
      c++;
    end
    spur = 1'b0;
    bus.key_wr_en = 1'b0;
    checks++;
    if (c !== LAT) begin
      failures++;
      $display("FAIL %s latency: out_valid in cycle %0d, required %0d", name, c, LAT);
    end
    checks++;
    if (pulses !== int'(NR)) begin
      failures++;
      $display("FAIL %s issue_count: %0d rnd_valid_o pulses, required %0d", name, pulses, NR);
    end
    checks++;
    if (lastbad !== 0) begin
      failures++;
      $display("FAIL %s rnd_last: %0d misplaced flags, required 0", name, lastbad);
    end
    first = bus.out_data;
    bus.out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== first || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s hold%0d: out_valid=%b out_data=%h in_ready=%b, required 1/%h/0",
                 name, h, bus.out_valid, bus.out_data, bus.in_ready, first);
      end
    end
    checks++;
    if ((bus.out_data === exp) !== (mode != 3)) begin
      failures++;
      $display("FAIL %s plaintext: got %h, reference %h (expect_equal=%0d)",
               name, bus.out_data, exp, mode != 3);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s release: out_valid=%b in_ready=%b busy=%b, required 0/1/0",
               name, bus.out_valid, bus.in_ready, bus.busy);
    end
  endtask

  task automatic simple_block(input string name, input int hold, input int mode);
    logic [127:0] pt;
    int w;
    pt = rand128();
    run_block(encrypt(pt), pt, name, hold, mode, 1'b0, '0, w);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.rnd_valid_o !== 1'b0 || bus.rnd_last_o !== 1'b0 || bus.out_data !== '0 ||
        bus.rnd_data_o !== '0 || bus.rnd_key_o !== '0) begin
      failures++;
      $display("FAIL reset_values: in_ready=%b busy=%b out_valid=%b rnd_valid_o=%b, required all 0",
               bus.in_ready, bus.busy, bus.out_valid, bus.rnd_valid_o);
    end
    reset = 1'b0;
    step();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b busy=%b, required 1/0", bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_fips();
    int w;
    load_keys(128'h000102030405060708090a0b0c0d0e0f);
    run_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff,
              "fips_c1", 0, 0, 1'b0, '0, w);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) begin
      load_keys(rand128());
      simple_block($sformatf("random%0d", i), int'($urandom_range(0, 3)), 0);
    end
  endtask

  task automatic test_backpressure();
    simple_block("backpressure", 20, 0);
  endtask

  task automatic test_key_lock();
    simple_block("key_lock_mid", 0, 2);
    simple_block("key_lock_next", 0, 0);
    for (int i = 11; i <= 12; i++) begin
      bus.key_wr_en   = 1'b1;
      bus.key_wr_idx  = IDX_W'(i);
      bus.key_wr_data = rand128();
      step();
    end
    bus.key_wr_en = 1'b0;
    simple_block("key_idx_oob", 0, 0);
  endtask

  task automatic test_key_same_cycle();
    logic [127:0] pt;
    int w;
    pt = rand128();
    bus.key_wr_en   = 1'b1;
    bus.key_wr_idx  = IDX_W'(NR);
    bus.key_wr_data = ~rk[NR];
    run_block(encrypt(pt), pt, "key_same_cycle_old", 0, 0, 1'b0, '0, w);
    pt = rand128();
    run_block(encrypt(pt), pt, "key_same_cycle_commit", 0, 3, 1'b0, '0, w);
    bus.key_wr_en   = 1'b1;
    bus.key_wr_data = rk[NR];
    step();
    bus.key_wr_en = 1'b0;
    simple_block("key_restored", 0, 0);
  endtask

  task automatic test_spurious();
    spur = 1'b1;
    step();
    spur = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
          bus.rnd_valid_o !== 1'b0) begin
        failures++;
        $display("FAIL spurious_idle%0d: busy=%b out_valid=%b in_ready=%b rnd_valid_o=%b, required 0/0/1/0",
                 i, bus.busy, bus.out_valid, bus.in_ready, bus.rnd_valid_o);
      end
      step();
    end
    simple_block("spurious_issue", 0, 1);
    simple_block("spurious_after", 0, 0);
  endtask

  task automatic test_reset_abort();
    int n, pulses, seen;
    bus.in_valid = 1'b1;
    bus.in_data  = rand128();
    n = 0;
    while (!bus.in_ready && n < 100) begin step(); n++; end
    step();
    bus.in_valid = 1'b0;
    pulses = 0;
    n = 0;
    while (pulses < 4 && n < 200) begin
      if (bus.rnd_valid_o === 1'b1) pulses++;
      step();
      n++;
    end
    checks++;
    if (pulses !== 4) begin
      failures++;
      $display("FAIL abort_reach_round4: %0d pulses, required 4", pulses);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.rnd_valid_o !== 1'b0 ||
        bus.in_ready !== 1'b0 || bus.rnd_last_o !== 1'b0 || bus.rnd_data_o !== '0 ||
        bus.rnd_key_o !== '0 || bus.out_data !== '0) begin
      failures++;
      $display("FAIL abort_outputs: busy=%b out_valid=%b rnd_valid_o=%b in_ready=%b, required all 0",
               bus.busy, bus.out_valid, bus.rnd_valid_o, bus.in_ready);
    end
    step();
    step();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL abort_quiet: %0d cycles with out_valid/busy set, required 0", seen);
    end
    simple_block("after_abort", 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [127:0] pt1, pt2, ct2;
    int w;
    pt1 = rand128();
    pt2 = rand128();
    ct2 = encrypt(pt2);
    run_block(encrypt(pt1), pt1, "b2b_first", 2, 0, 1'b1, ct2, w);
    run_block(ct2, pt2, "b2b_second", 0, 0, 1'b0, '0, w);
    checks++;
    if (w !== 0) begin
      failures++;
      $display("FAIL b2b_accept_gap: second block waited %0d cycles, required 0", w);
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.key_wr_en   = 1'b0;
    bus.key_wr_idx  = '0;
    bus.key_wr_data = '0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.out_ready   = 1'b0;
    build_sbox();
    test_reset();
    test_fips();
    test_random();
    test_backpressure();
    test_key_lock();
    test_key_same_cycle();
    test_spurious();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
